// File: rtl/dmem_server_if.sv
// Memory-stage request bus between the pipeline (master) and the data memory
// responder (slave).
interface dmem_server_if;
   // A request is presented with memreqM=1 and must be held until a cycle with
   // stallM=0; the pipeline advances on that edge and may present the next one.
   logic        memreqM;
   logic        memwriteM;
   logic        sbM;
   logic [31:0] aluoutM;
   logic [31:0] writedataM;
   logic [31:0] readdataM;
   logic        rdvalidM;
   logic        stallM;

   modport master (
      output memreqM, memwriteM, sbM, aluoutM, writedataM,
      input  readdataM, rdvalidM, stallM
   );

   modport slave (
      input  memreqM, memwriteM, sbM, aluoutM, writedataM,
      output readdataM, rdvalidM, stallM
   );
endinterface

// File: rtl/dmem_server.sv
// Multi-cycle data memory responder: latches one load/store, stalls the pipeline
// for LATENCY cycles, then commits the store (with byte merge) or returns the word.
module dmem_server #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic          clk,
   input  logic          reset,
   dmem_server_if.slave  bus,
   output logic [1:0]    state_dbg
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [1:0]      lane_q, lane_d;
   logic [31:0]     wdata_q, wdata_d;
   logic            we_q, we_d;
   logic            sb_q, sb_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            rdvalid_q, rdvalid_d;

   logic [31:0]     mem_q [DEPTH];
   logic            mem_we;
   logic [31:0]     merge_word;
   logic            unused_addr_bits;

   assign unused_addr_bits = ^bus.aluoutM[31:AW+2];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      lane_d    = lane_q;
      wdata_d   = wdata_q;
      we_d      = we_q;
      sb_d      = sb_q;
      rdata_d   = rdata_q;
      rdvalid_d = 1'b0;
      mem_we    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.memreqM) begin
               idx_d   = bus.aluoutM[AW+1:2];
               lane_d  = bus.aluoutM[1:0];
               wdata_d = bus.writedataM;
               we_d    = bus.memwriteM;
               sb_d    = bus.sbM;
               cnt_d   = CNT_INIT;
               state_d = (LATENCY == 1) ? DONE : BUSY;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            if (we_q) begin
               mem_we = 1'b1;
            end else begin
               rdata_d   = mem_q[idx_q];
               rdvalid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Byte store is a read-modify-write of the addressed word in the DONE cycle.
   always_comb begin
      merge_word = wdata_q;
      if (sb_q) begin
         merge_word = mem_q[idx_q];
         merge_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         lane_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         sb_q      <= 1'b0;
         rdata_q   <= '0;
         rdvalid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         lane_q    <= lane_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         sb_q      <= sb_d;
         rdata_q   <= rdata_d;
         rdvalid_q <= rdvalid_d;
      end
   end

   // Array is not reset; reset forces IDLE asynchronously, which drops the commit.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[idx_q] <= merge_word;
      end
   end

   assign bus.stallM    = ((state_q == IDLE) && bus.memreqM) || (state_q == BUSY);
   assign bus.readdataM = rdata_q;
   assign bus.rdvalidM  = rdvalid_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_dmem_server.sv
// Bench for dmem_server: three instances (LATENCY 2, 1, 4) checked against an
// address-keyed word model with byte-lane masking.
module tb_dmem_server;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_a, req_b, req_c;
   logic        we_i, sb_i;
   logic [31:0] addr_i, wdata_i;
   logic [1:0]  dbg_a, dbg_b, dbg_c;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem_m [int];
   logic [31:0] exp_rd [3];

   always #5 clk = ~clk;

   dmem_server_if bus_a ();
   dmem_server_if bus_b ();
   dmem_server_if bus_c ();

   assign bus_a.memreqM = req_a;
   assign bus_b.memreqM = req_b;
   assign bus_c.memreqM = req_c;
   assign bus_a.memwriteM = we_i;
   assign bus_b.memwriteM = we_i;
   assign bus_c.memwriteM = we_i;
   assign bus_a.sbM = sb_i;
   assign bus_b.sbM = sb_i;
   assign bus_c.sbM = sb_i;
   assign bus_a.aluoutM = addr_i;
   assign bus_b.aluoutM = addr_i;
   assign bus_c.aluoutM = addr_i;
   assign bus_a.writedataM = wdata_i;
   assign bus_b.writedataM = wdata_i;
   assign bus_c.writedataM = wdata_i;

   dmem_server #(.DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
      .clk(clk), .reset(reset), .bus(bus_a), .state_dbg(dbg_a));
   dmem_server #(.DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
      .clk(clk), .reset(reset), .bus(bus_b), .state_dbg(dbg_b));
   dmem_server #(.DEPTH(DEPTH), .LATENCY(4)) u_lat4 (
      .clk(clk), .reset(reset), .bus(bus_c), .state_dbg(dbg_c));

   function automatic int lat_of(input int which);
      case (which)
         0: return 2;
         1: return 1;
         default: return 4;
      endcase
   endfunction

   function automatic logic get_stall(input int which);
      case (which)
         0: return bus_a.stallM;
         1: return bus_b.stallM;
         default: return bus_c.stallM;
      endcase
   endfunction

   function automatic logic get_rv(input int which);
      case (which)
         0: return bus_a.rdvalidM;
         1: return bus_b.rdvalidM;
         default: return bus_c.rdvalidM;
      endcase
   endfunction

   function automatic logic [31:0] get_rd(input int which);
      case (which)
         0: return bus_a.readdataM;
         1: return bus_b.readdataM;
         default: return bus_c.readdataM;
      endcase
   endfunction

   task automatic set_req(input int which, input logic v);
      case (which)
         0: req_a = v;
         1: req_b = v;
         default: req_c = v;
      endcase
   endtask

   // Starts just after a falling edge; ends 1 time unit into the writeback cycle.
   task automatic do_req(input int which, input logic w, input logic s,
                         input logic [31:0] a, input logic [31:0] d,
                         input bit scramble, input bit release_req);
      int n;
      int key;
      int lane;
      logic [31:0] old;
      we_i    = w;
      sb_i    = s;
      addr_i  = a;
      wdata_i = d;
      set_req(which, 1'b1);
      key = which * DEPTH + int'((a >> 2) % DEPTH);
      #1;
      n = 0;
      while (get_stall(which) === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
         if (scramble) begin
            addr_i  = $urandom;
            wdata_i = $urandom;
         end
         #1;
      end
      total++;
      if (n != lat_of(which)) begin
         bad++;
         $display("FAIL stall_len dut=%0d got=%0d want=%0d", which, n, lat_of(which));
      end
      total++;
      if (get_rv(which) !== 1'b0) begin
         bad++;
         $display("FAIL rdvalid_in_done dut=%0d got=%b want=0", which, get_rv(which));
      end
      if (w) begin
         if (s) begin
            lane = int'(a[1:0]);
            old  = mem_m.exists(key) ? mem_m[key] : 32'h0;
            mem_m[key] = (old & ~(32'hFF << (8 * lane))) | ({24'h0, d[7:0]} << (8 * lane));
         end else begin
            mem_m[key] = d;
         end
      end else if (mem_m.exists(key)) begin
         exp_rd[which] = mem_m[key];
      end
      @(negedge clk);
      if (release_req) set_req(which, 1'b0);
      #1;
      total++;
      if (get_rv(which) !== !w) begin
         bad++;
         $display("FAIL rdvalid_wb dut=%0d got=%b want=%b", which, get_rv(which), !w);
      end
      total++;
      if (get_rd(which) !== exp_rd[which]) begin
         bad++;
         $display("FAIL readdata dut=%0d addr=%h got=%h want=%h", which, a, get_rd(which), exp_rd[which]);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
      we_i = 1'b0; sb_i = 1'b0; addr_i = '0; wdata_i = '0;
      repeat (2) @(negedge clk);
      #1;
      for (int w = 0; w < 3; w++) begin
         exp_rd[w] = 32'h0;
         total++;
         if (get_stall(w) !== 1'b0) begin
            bad++;
            $display("FAIL reset_stall dut=%0d got=%b want=0", w, get_stall(w));
         end
         total++;
         if (get_rv(w) !== 1'b0) begin
            bad++;
            $display("FAIL reset_rdvalid dut=%0d got=%b want=0", w, get_rv(w));
         end
         total++;
         if (get_rd(w) !== 32'h0) begin
            bad++;
            $display("FAIL reset_readdata dut=%0d got=%h want=0", w, get_rd(w));
         end
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_word();
      do_req(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1);
      do_req(0, 1'b0, 1'b0, 32'h10, $urandom, 1'b0, 1'b1);
      total++;
      if (get_rd(0) !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL word_load got=%h want=deadbeef", get_rd(0));
      end
      @(negedge clk);
      #1;
      total++;
      if (get_rv(0) !== 1'b0) begin
         bad++;
         $display("FAIL rdvalid_pulse got=%b want=0", get_rv(0));
      end
      total++;
      if (get_rd(0) !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL readdata_hold got=%h want=deadbeef", get_rd(0));
      end
      @(negedge clk);
   endtask

   task automatic test_byte_lanes();
      do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1);
      do_req(0, 1'b1, 1'b1, 32'h22, 32'hFFFFFFA5, 1'b0, 1'b1);
      do_req(0, 1'b1, 1'b1, 32'h21, 32'h1234563C, 1'b0, 1'b1);
      do_req(0, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1);
      total++;
      if (get_rd(0) !== 32'h00A53C00) begin
         bad++;
         $display("FAIL byte_lanes got=%h want=00a53c00", get_rd(0));
      end
      @(negedge clk);
   endtask

   task automatic test_addr_wrap();
      do_req(0, 1'b1, 1'b0, 32'h400, 32'h12345678, 1'b0, 1'b1);
      do_req(0, 1'b0, 1'b0, 32'h000, 32'h0, 1'b0, 1'b1);
      total++;
      if (get_rd(0) !== 32'h12345678) begin
         bad++;
         $display("FAIL addr_wrap got=%h want=12345678", get_rd(0));
      end
      do_req(0, 1'b1, 1'b0, 32'h403, 32'hCAFEF00D, 1'b0, 1'b1);
      do_req(0, 1'b0, 1'b0, 32'h000, 32'h0, 1'b0, 1'b1);
      total++;
      if (get_rd(0) !== 32'hCAFEF00D) begin
         bad++;
         $display("FAIL misaligned_store got=%h want=cafef00d", get_rd(0));
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      do_req(1, 1'b1, 1'b0, 32'h40, 32'hA0A0A0A0, 1'b0, 1'b1);
      do_req(1, 1'b1, 1'b0, 32'h44, 32'hB1B1B1B1, 1'b0, 1'b1);
      @(negedge clk);
      do_req(1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0);
      do_req(1, 1'b0, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0);
      do_req(1, 1'b1, 1'b0, 32'h48, 32'h5EED5EED, 1'b0, 1'b0);
      do_req(1, 1'b0, 1'b0, 32'h48, 32'h0, 1'b0, 1'b1);
      total++;
      if (get_rd(1) !== 32'h5EED5EED) begin
         bad++;
         $display("FAIL b2b_load got=%h want=5eed5eed", get_rd(1));
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_busy();
      do_req(2, 1'b1, 1'b0, 32'h80, 32'h11111111, 1'b0, 1'b1);
      @(negedge clk);
      we_i = 1'b1; sb_i = 1'b0; addr_i = 32'h80; wdata_i = 32'hFFFFFFFF;
      req_c = 1'b1;
      @(negedge clk);
      @(negedge clk);
      req_c = 1'b0;
      reset = 1'b0;
      #1;
      total++;
      if (bus_c.stallM !== 1'b0) begin
         bad++;
         $display("FAIL rst_busy_stall got=%b want=0", bus_c.stallM);
      end
      total++;
      if (bus_c.readdataM !== 32'h0) begin
         bad++;
         $display("FAIL rst_busy_readdata got=%h want=0", bus_c.readdataM);
      end
      for (int w = 0; w < 3; w++) exp_rd[w] = 32'h0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      do_req(2, 1'b0, 1'b0, 32'h80, 32'h0, 1'b0, 1'b1);
      total++;
      if (get_rd(2) !== 32'h11111111) begin
         bad++;
         $display("FAIL rst_busy_dropped got=%h want=11111111", get_rd(2));
      end
      @(negedge clk);
   endtask

   task automatic test_input_change();
      do_req(0, 1'b1, 1'b0, 32'hC4, 32'h600DF00D, 1'b1, 1'b1);
      do_req(0, 1'b0, 1'b0, 32'hC4, 32'h0, 1'b1, 1'b1);
      do_req(2, 1'b1, 1'b1, 32'h81, 32'h000000EE, 1'b1, 1'b1);
      do_req(2, 1'b0, 1'b0, 32'h80, 32'h0, 1'b1, 1'b1);
      total++;
      if (get_rd(2) !== 32'h1111EE11) begin
         bad++;
         $display("FAIL input_change got=%h want=1111ee11", get_rd(2));
      end
      @(negedge clk);
   endtask

   task automatic test_random(input int which, input int n_ops);
      logic [31:0] known_q [$];
      logic [31:0] a;
      int op;
      int k;
      bit rel;
      known_q.delete();
      for (int i = 0; i < n_ops; i++) begin
         op  = (known_q.size() == 0) ? 0 : $urandom_range(0, 2);
         rel = $urandom_range(0, 1);
         if (op == 0) begin
            a = $urandom;
            known_q.push_back(a);
            do_req(which, 1'b1, 1'b0, a, $urandom, $urandom_range(0, 1), rel);
         end else begin
            k = $urandom_range(0, known_q.size() - 1);
            a = known_q[k];
            a[1:0] = 2'($urandom_range(0, 3));
            do_req(which, (op == 1), (op == 1), a, $urandom, $urandom_range(0, 1), rel);
         end
         if (rel) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      set_req(which, 1'b0);
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte_lanes();
      test_addr_wrap();
      test_back_to_back();
      test_reset_mid_busy();
      test_input_change();
      test_random(0, 40);
      test_random(1, 40);
      test_random(2, 40);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dmem_server.md
# dmem_server

Multi-cycle data-memory responder serving the pipeline's memory-stage load/store requests. It accepts one request at a time, holds the pipeline with a stall while a configurable access latency elapses, then commits the store or returns the read word. Byte stores are merged into the word here; byte loads return the full word and the writeback stage selects the byte lane. It sits between the datapath's memory stage and the hazard unit, which ORs `stallM` into its stall/flush logic.

## Interface
- `DEPTH`, 256: memory size in 32-bit words; power of two, ≥ 4.
- `LATENCY`, 2: cycles from request acceptance to the response cycle; ≥ 1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `memreqM`  in  1  request valid (load or store in the memory stage).
- `memwriteM`  in  1  1 = store, 0 = load.
- `sbM`  in  1  store-byte qualifier; meaningful only when `memwriteM`=1.
- `aluoutM`  in  32  byte address.
- `writedataM`  in  32  store data.
- `readdataM`  out  32  loaded word.
- `rdvalidM`  out  1  one-cycle pulse when `readdataM` carries a new load result.
- `stallM`  out  1  hold request: pipeline must freeze fetch, decode, execute and memory stages.

## Operation
- FSM states are IDLE, BUSY and DONE.
- **IDLE**
  - If `memreqM`=1: latch address, data, `memwriteM` and `sbM`; load counter with `LATENCY`-1.
  - Next state is DONE if `LATENCY`=1, else BUSY.
  - If `memreqM`=0: stay in IDLE.
- **BUSY**
  - Decrement the counter each cycle.
  - When the counter equals 1, go to DONE.
- **DONE**
  - Perform the access using the latched request.
  - Next state is always IDLE.
  - `memreqM` is ignored in DONE: the pipeline still presents the same request until this edge.
- **Word index:** `aluoutM[log2(DEPTH)+1:2]`. Higher address bits are ignored, so addresses wrap modulo `DEPTH`×4.
- **Store word:** writes all 32 bits. `aluoutM[1:0]` is ignored (no alignment trap).
- **Store byte:** writes `writedataM[7:0]` into lane `aluoutM[1:0]`. Lane 0 is bits 7:0 and lane 3 is bits 31:24. The other lanes are unchanged.
- **Load:** `readdataM` gets the full word and `rdvalidM` pulses. `readdataM` holds its value until the next load's DONE. Stores never change `readdataM`.
- **Request stability:** request inputs are sampled only in IDLE. Changes during BUSY or DONE have no effect (latched copy used).
- **Array contents:** not reset; undefined at power-up and retained across reset.

## Timing
- **Reset values:** state IDLE, counter 0, `readdataM`=0, `rdvalidM`=0, `stallM`=0. Any pending latched request is discarded and its store is not committed.
- **`stallM`** is combinational and equals (IDLE & `memreqM`) | BUSY. It is 0 in DONE, so the pipeline advances at the DONE edge.
- **Stall length:** exactly `LATENCY` cycles per request. Occupancy is `LATENCY`+1 cycles, counting from the first IDLE cycle with `memreqM`=1 through DONE.
- **Output timing:** `readdataM` and `rdvalidM` are registered. They update at the edge ending DONE and are valid in the cycle after DONE, which is the writeback cycle.
- **Store commit:** the store is committed at the edge ending DONE. A load in the next request sees the new data.
- **Back-to-back requests:** the next request appears in the IDLE cycle after DONE and is accepted there, with no dead cycle beyond DONE.
- **Reset asserted mid-BUSY:** the FSM goes to IDLE immediately, `stallM` drops asynchronously through the IDLE term only if `memreqM`=0, and the store is dropped.

## Test plan
- **Store/load word**, `LATENCY`=2: store word 0xDEADBEEF to 0x10, then load 0x10 → `stallM` high for exactly 2 cycles per request; `readdataM`=0xDEADBEEF with a one-cycle `rdvalidM`.
- **Store byte lanes:** preload word 0x00000000 at 0x20; store byte 0xA5 to 0x22 and 0x3C to 0x21; load 0x20 → 0x00A53C00.
- **Address wrap**, `DEPTH`=256: store word 0x12345678 to 0x400, load 0x000 → 0x12345678. Misaligned store word to 0x403 also writes word 0.
- **`LATENCY`=1 back-to-back:** load, load, store, load with `memreqM` held high → each stalls 1 cycle; exactly 2 cycles per request; no dropped or duplicated access.
- **Reset mid-BUSY**, `LATENCY`=4: store 0xFFFFFFFF to a word holding 0x11111111 and pulse `reset` low in the second BUSY cycle → `stallM`=0 and `readdataM`=0 after reset; a later load returns 0x11111111.
- **Input change during stall:** change `aluoutM` and `writedataM` while `stallM`=1 → the access uses the values from the accepting IDLE cycle.
